stream_argmax: RTL and testbench

//  Sequential, parametrised argmax for classifier output scores; successor to the combinational 10-input max tree.

---
 rtl/stream_argmax.sv | 143 ++++++++++++++
 tb/tb_stream_argmax.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_argmax.sv
// Streaming argmax over one frame of classifier scores: tracks best and runner-up,
// then presents class index, max score and saturating margin on a result handshake.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_COLLECT | accepting score beats, updating best / runner-up / index
// S_HOLD    | frame result presented on res_*, waiting for res_ready
module stream_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int DATA_W      = 27,
  parameter bit SIGNED_CMP  = 1'b1,
  localparam int IDX_W      = $clog2(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_idx,
  output logic [DATA_W-1:0] res_max,
  output logic [DATA_W-1:0] res_margin,
  output logic              res_err,
  output logic [3:0]        hex_out
);

  localparam logic [0:0] S_COLLECT = 1'b0;
  localparam logic [0:0] S_HOLD    = 1'b1;

  localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(NUM_CLASSES - 1);
  localparam logic [DATA_W-1:0] MIN_VAL   = SIGNED_CMP ? {1'b1, {(DATA_W-1){1'b0}}}
                                                       : {DATA_W{1'b0}};
  // Largest margin representable as a non-negative score in the configured number format.
  localparam logic [DATA_W:0]   MARGIN_CAP = SIGNED_CMP ? {2'b00, {(DATA_W-1){1'b1}}}
                                                        : {1'b0, {DATA_W{1'b1}}};

  logic [0:0]        state;
  logic [IDX_W-1:0]  beat_cnt;
  logic [IDX_W-1:0]  best_idx;
  logic [DATA_W-1:0] best;
  logic [DATA_W-1:0] second;

  logic              beat;
  logic              first_beat;
  logic              frame_end;
  logic              frame_err;
  logic [DATA_W-1:0] nxt_best;
  logic [DATA_W-1:0] nxt_second;
  logic [IDX_W-1:0]  nxt_idx;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] margin;
  logic [3:0]        hex_nxt;

  function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (SIGNED_CMP) return $signed(a) > $signed(b);
    else            return a > b;
  endfunction

  function automatic logic [DATA_W:0] ext(input logic [DATA_W-1:0] x);
    if (SIGNED_CMP) return {x[DATA_W-1], x};
    else            return {1'b0, x};
  endfunction

  // Handshake readiness depends on state only, never on in_valid or res_ready.
  assign in_ready   = (state == S_COLLECT);
  assign res_valid  = (state == S_HOLD);

  assign beat       = in_valid && in_ready;
  assign first_beat = (beat_cnt == '0);
  assign frame_end  = beat && (in_last || (beat_cnt == LAST_BEAT));
  assign frame_err  = !in_last || (beat_cnt != LAST_BEAT);

  always_comb begin
    nxt_best   = best;
    nxt_second = second;
    nxt_idx    = best_idx;
    if (first_beat) begin
      nxt_best   = in_data;
      nxt_second = MIN_VAL;
      nxt_idx    = '0;
    end else if (greater(in_data, best)) begin
      nxt_second = best;
      nxt_best   = in_data;
      nxt_idx    = beat_cnt;
    end else if (greater(in_data, second)) begin
      nxt_second = in_data;
    end
  end

  // A one-beat frame has no runner-up; report the widest margin.
  always_comb begin
    diff    = first_beat ? {(DATA_W+1){1'b1}} : (ext(nxt_best) - ext(nxt_second));
    margin  = (diff > MARGIN_CAP) ? MARGIN_CAP[DATA_W-1:0] : diff[DATA_W-1:0];
    hex_nxt = 4'hF;
    if (!frame_err && (32'(nxt_idx) <= 32'd9)) hex_nxt = 4'(nxt_idx);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_COLLECT;
      beat_cnt   <= '0;
      best       <= '0;
      second     <= '0;
      best_idx   <= '0;
      res_idx    <= '0;
      res_max    <= '0;
      res_margin <= '0;
      res_err    <= 1'b0;
      hex_out    <= 4'hF;
    end else begin
      case (state)
        S_COLLECT: begin
          if (beat) begin
            best     <= nxt_best;
            second   <= nxt_second;
            best_idx <= nxt_idx;
            if (frame_end) begin
              state      <= S_HOLD;
              beat_cnt   <= '0;
              res_idx    <= nxt_idx;
              res_max    <= nxt_best;
              res_margin <= margin;
              res_err    <= frame_err;
              hex_out    <= hex_nxt;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            state    <= S_COLLECT;
            beat_cnt <= '0;
          end
        end
        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_argmax.sv
// Bench for stream_argmax: signed and unsigned 10-class instances share stimulus,
// a 16-class signed instance has its own; expected results come from a batch argmax model.
module tb_stream_argmax;

  localparam int DW = 27;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          a_valid, a_last, a_rready;
  logic [DW-1:0] a_data;
  logic          w_valid, w_last, w_rready;
  logic [DW-1:0] w_data;

  logic          a_in_ready, a_res_valid, a_res_err;
  logic [3:0]    a_res_idx, a_hex;
  logic [DW-1:0] a_res_max, a_res_margin;
  logic          u_in_ready, u_res_valid, u_res_err;
  logic [3:0]    u_res_idx, u_hex;
  logic [DW-1:0] u_res_max, u_res_margin;
  logic          w_in_ready, w_res_valid, w_res_err;
  logic [3:0]    w_res_idx, w_hex;
  logic [DW-1:0] w_res_max, w_res_margin;

  stream_argmax #(.NUM_CLASSES(10), .DATA_W(DW), .SIGNED_CMP(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_in_ready), .in_data(a_data),
    .in_last(a_last), .res_valid(a_res_valid), .res_ready(a_rready), .res_idx(a_res_idx),
    .res_max(a_res_max), .res_margin(a_res_margin), .res_err(a_res_err), .hex_out(a_hex));

  stream_argmax #(.NUM_CLASSES(10), .DATA_W(DW), .SIGNED_CMP(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(u_in_ready), .in_data(a_data),
    .in_last(a_last), .res_valid(u_res_valid), .res_ready(a_rready), .res_idx(u_res_idx),
    .res_max(u_res_max), .res_margin(u_res_margin), .res_err(u_res_err), .hex_out(u_hex));

  stream_argmax #(.NUM_CLASSES(16), .DATA_W(DW), .SIGNED_CMP(1'b1)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_in_ready), .in_data(w_data),
    .in_last(w_last), .res_valid(w_res_valid), .res_ready(w_rready), .res_idx(w_res_idx),
    .res_max(w_res_max), .res_margin(w_res_margin), .res_err(w_res_err), .hex_out(w_hex));

  typedef struct packed {
    logic [7:0]    idx;
    logic [DW-1:0] mx;
    logic [DW-1:0] mg;
    logic          err;
    logic [3:0]    hex;
  } exp_t;

  exp_t          qa[$], qu[$], qw[$];
  logic [DW-1:0] frame_sc[16];
  int            t1[10] = '{5, -3, 12, 7, 12, 0, -100, 1, 2, 3};
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit gt(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sgn);
    if (sgn) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  // Batch reference: first maximum wins ties, runner-up is the largest of the remaining beats.
  function automatic exp_t model(input int n, input bit sgn, input int ncls, input bit lastf);
    exp_t          e;
    int            bi = 0;
    bit            found = 1'b0;
    logic [DW-1:0] sec = '0;
    logic [DW:0]   d, cap;
    for (int j = 1; j < n; j++) if (gt(frame_sc[j], frame_sc[bi], sgn)) bi = j;
    for (int j = 0; j < n; j++)
      if (j != bi && (!found || gt(frame_sc[j], sec, sgn))) begin
        sec   = frame_sc[j];
        found = 1'b1;
      end
    cap = sgn ? 28'h3FFFFFF : 28'h7FFFFFF;
    if (!found) d = cap;
    else if (sgn) d = {frame_sc[bi][DW-1], frame_sc[bi]} - {sec[DW-1], sec};
    else d = {1'b0, frame_sc[bi]} - {1'b0, sec};
    if (d > cap) d = cap;
    e.idx = 8'(bi);
    e.mx  = frame_sc[bi];
    e.mg  = d[DW-1:0];
    e.err = (n != ncls) || !lastf;
    e.hex = (e.err || bi > 9) ? 4'hF : 4'(bi);
    return e;
  endfunction

  task automatic set_in(input int grp, input bit v, input logic [DW-1:0] d, input bit l);
    if (grp == 0) begin a_valid = v; a_data = d; a_last = l; end
    else begin w_valid = v; w_data = d; w_last = l; end
  endtask

  function automatic bit in_rdy(input int grp);
    return (grp == 0) ? (a_in_ready && u_in_ready) : w_in_ready;
  endfunction

  function automatic bit rv(input int grp);
    return (grp == 0) ? (a_res_valid && u_res_valid) : w_res_valid;
  endfunction

  task automatic cmp_res(input string p, input exp_t e, input logic [3:0] idx,
                         input logic [DW-1:0] mx, input logic [DW-1:0] mg,
                         input logic err, input logic [3:0] hex);
    chk({p, "_idx"}, idx, e.idx);
    chk({p, "_max"}, mx, e.mx);
    chk({p, "_margin"}, mg, e.mg);
    chk({p, "_err"}, err, e.err);
    chk({p, "_hex"}, hex, e.hex);
  endtask

  task automatic check_reset_outputs();
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_res_valid", a_res_valid, 0);
    chk("rst_a_res", {a_res_idx, a_res_max, a_res_margin, a_res_err}, 0);
    chk("rst_a_hex", a_hex, 4'hF);
    chk("rst_u_res", {u_res_valid, u_res_idx, u_res_max, u_res_margin, u_res_err}, 0);
    chk("rst_u_hex", u_hex, 4'hF);
    chk("rst_w_res", {w_res_valid, w_res_idx, w_res_max, w_res_margin, w_res_err}, 0);
    chk("rst_w_hex", w_hex, 4'hF);
  endtask

  // Called at a negedge; returns at the negedge after the final beat is accepted.
  task automatic send_frame(input int grp, input int n, input bit lastf, input bit rnd, input bit push);
    int t;
    if (push) begin
      if (grp == 0) begin
        qa.push_back(model(n, 1'b1, 10, lastf));
        qu.push_back(model(n, 1'b0, 10, lastf));
      end else begin
        qw.push_back(model(n, 1'b1, 16, lastf));
      end
    end
    for (int k = 0; k < n; k++) begin
      if (rnd) begin
        int gap = $urandom_range(0, 3);
        repeat (gap) begin
          set_in(grp, 1'b0, DW'($urandom), 1'b1);
          @(negedge clk);
        end
      end
      set_in(grp, 1'b1, frame_sc[k], lastf && (k == n - 1));
      t = 0;
      while (!in_rdy(grp) && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (t >= 50) begin
        checks++;
        errors++;
        $error("FAIL in_ready_timeout observed=0 expected=1");
        set_in(grp, 1'b0, '0, 1'b0);
        return;
      end
      @(negedge clk);
    end
    set_in(grp, 1'b0, '0, 1'b0);
  endtask

  task automatic get_result(input int grp, input int hold);
    exp_t ea, eu;
    int   t = 0;
    while (!rv(grp) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("latency", t, 0);
    if (!rv(grp)) return;
    if ((grp == 0 && (qa.size() == 0 || qu.size() == 0)) || (grp != 0 && qw.size() == 0)) begin
      checks++;
      errors++;
      $error("FAIL unexpected_result observed=res_valid expected=none");
      return;
    end
    if (grp == 0) begin
      ea = qa.pop_front();
      eu = qu.pop_front();
    end else begin
      ea = qw.pop_front();
      eu = ea;
    end
    for (int c = 0; c <= hold; c++) begin
      if (c > 0) begin
        @(negedge clk);
        chk("hold_in_ready", in_rdy(grp), 0);
        chk("hold_res_valid", rv(grp), 1);
      end
      if (grp == 0) begin
        cmp_res("a", ea, a_res_idx, a_res_max, a_res_margin, a_res_err, a_hex);
        cmp_res("u", eu, u_res_idx, u_res_max, u_res_margin, u_res_err, u_hex);
      end else begin
        cmp_res("w", ea, w_res_idx, w_res_max, w_res_margin, w_res_err, w_hex);
      end
    end
    if (grp == 0) a_rready = 1'b1; else w_rready = 1'b1;
    @(negedge clk);
    if (grp == 0) a_rready = 1'b0; else w_rready = 1'b0;
    chk("release_in_ready", in_rdy(grp), 1);
    chk("release_res_valid", rv(grp), 0);
    chk("release_hex_held", (grp == 0) ? {a_hex, u_hex} : {w_hex, w_hex}, {ea.hex, eu.hex});
  endtask

  task automatic load_t1();
    for (int k = 0; k < 10; k++) frame_sc[k] = DW'(t1[k]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    set_in(0, 1'b0, '0, 1'b0);
    set_in(1, 1'b0, '0, 1'b0);
    a_rready = 1'b0;
    w_rready = 1'b0;
    for (int k = 0; k < 16; k++) frame_sc[k] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Ties keep the lower index.
    load_t1();
    send_frame(0, 10, 1'b1, 1'b0, 1'b1);
    get_result(0, 0);

    // All negative: signed picks the zero, unsigned the largest bit pattern.
    for (int k = 0; k < 10; k++) frame_sc[k] = DW'(k - 9);
    send_frame(0, 10, 1'b1, 1'b0, 1'b1);
    get_result(0, 0);

    // Consumer stalls for 20 cycles.
    load_t1();
    send_frame(0, 10, 1'b1, 1'b0, 1'b1);
    get_result(0, 20);

    // Early last on beat 4, then a full frame clears the error.
    for (int k = 0; k < 5; k++) frame_sc[k] = DW'(10 * k % 7);
    send_frame(0, 5, 1'b1, 1'b0, 1'b1);
    get_result(0, 0);
    load_t1();
    send_frame(0, 10, 1'b1, 1'b0, 1'b1);
    get_result(0, 0);

    // Missing last on the final beat, and a one-beat frame.
    for (int k = 0; k < 10; k++) frame_sc[k] = DW'(k * 3 + 1);
    send_frame(0, 10, 1'b0, 1'b0, 1'b1);
    get_result(0, 0);
    frame_sc[0] = DW'(-7);
    send_frame(0, 1, 1'b1, 1'b0, 1'b1);
    get_result(0, 0);

    // Gaps in in_valid with garbage data give the same result.
    load_t1();
    send_frame(0, 10, 1'b1, 1'b1, 1'b1);
    get_result(0, 0);

    // Reset while beat 5 is being offered.
    send_frame(0, 5, 1'b0, 1'b0, 1'b0);
    set_in(0, 1'b1, frame_sc[5], 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    set_in(0, 1'b0, '0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame(0, 10, 1'b1, 1'b0, 1'b1);
    get_result(0, 0);

    // 16 classes: winner at 12 with extreme runner-up saturates the margin.
    for (int k = 0; k < 16; k++) frame_sc[k] = 27'h4000000;
    frame_sc[12] = 27'h3FFFFFF;
    send_frame(1, 16, 1'b1, 1'b0, 1'b1);
    get_result(1, 0);
    for (int k = 0; k < 16; k++) frame_sc[k] = DW'((k * 5) % 11);
    send_frame(1, 16, 1'b1, 1'b0, 1'b1);
    get_result(1, 0);
    for (int k = 0; k < 4; k++) frame_sc[k] = DW'(100 - k);
    send_frame(1, 4, 1'b1, 1'b0, 1'b1);
    get_result(1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
